fifo_wr_arbiter: RTL

Round-robin write-port arbiter that shares one synchronous FIFO between NUM_REQ producers. It selects one requester per cycle and drives the FIFO's wr_en/data_in, and it never writes while full. It also checks the FIFO's write acknowledgement and overflow responses and parks in an error state on any protocol violation. It sits between the producer blocks and the FIFO write side; the FIFO read side is untouched.

---
 rtl/fifo_wr_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one synchronous FIFO write port between NUM_REQ producers.
// Latency: zero cycles from req to gnt/wr_en/data_in; status outputs are registered.
// Backpressure: no grant while full, in ERR or in an error-detect cycle; requesters hold until granted.
module fifo_wr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int FIFO_WIDTH = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            gnt,
   output logic                          wr_en,
   output logic [FIFO_WIDTH-1:0]         data_in,
   input  logic                          full,
   input  logic                          wr_ack,
   input  logic                          overflow,
   input  logic                          clear_err,
   output logic [1:0]                    arb_state,
   output logic                          ack_err,
   output logic                          ovf_err,
   output logic [15:0]                   wr_count
);

   localparam int IDX_W = $clog2(NUM_REQ);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_STALL = 2'd1,
      ST_ERR   = 2'd2
   } state_t;

   state_t                state;
   logic [IDX_W-1:0]      last_gnt;
   logic                  pend_ack;

   logic                  err_ack;
   logic                  err_ovf;
   logic                  err_det;
   logic                  found;
   logic [IDX_W-1:0]      sel_idx;
   logic [IDX_W-1:0]      cand_idx;
   int                    cand;
   logic                  grant_ok;
   logic [FIFO_WIDTH-1:0] data_sel;

   // Ack must track the previous cycle's write exactly; overflow is always fatal.
   always_comb begin
      err_ack = pend_ack ^ wr_ack;
      err_ovf = overflow;
      err_det = err_ack | err_ovf;
   end

   // Round-robin search starting just after the last granted requester.
   always_comb begin
      found    = 1'b0;
      sel_idx  = '0;
      cand     = 0;
      cand_idx = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand     = (int'(last_gnt) + k) % NUM_REQ;
         cand_idx = IDX_W'(cand);
         if (!found && req[cand_idx]) begin
            found   = 1'b1;
            sel_idx = cand_idx;
         end
      end
   end

   // Data mux over the granted slice, using constant slice positions.
   always_comb begin
      data_sel = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (sel_idx == IDX_W'(i)) begin
            data_sel = req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
         end
      end
   end

   // Grant only when nothing blocks the write port; reset forces the write side idle.
   always_comb begin
      grant_ok = !rst && (state != ST_ERR) && !full && !err_det && found;
      gnt      = grant_ok ? (NUM_REQ'(1) << sel_idx) : '0;
      wr_en    = grant_ok;
      data_in  = grant_ok ? data_sel : '0;
   end

   // Control FSM, round-robin pointer, pending-ack tracking, sticky errors and write counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_RUN;
         last_gnt <= IDX_W'(NUM_REQ - 1);
         pend_ack <= 1'b0;
         ack_err  <= 1'b0;
         ovf_err  <= 1'b0;
         wr_count <= 16'd0;
      end else begin
         pend_ack <= wr_en;

         if (wr_en) begin
            last_gnt <= sel_idx;
            wr_count <= wr_count + 16'd1;
         end

         // A clear in ERR wipes old causes but still records anything new this cycle.
         if ((state == ST_ERR) && clear_err) begin
            ack_err  <= err_ack;
            ovf_err  <= err_ovf;
            pend_ack <= 1'b0;
         end else begin
            ack_err <= ack_err | err_ack;
            ovf_err <= ovf_err | err_ovf;
         end

         if (err_det) begin
            state <= ST_ERR;
         end else begin
            case (state)
               ST_RUN:   if (full && |req) state <= ST_STALL;
               ST_STALL: if (!full)        state <= ST_RUN;
               ST_ERR:   if (clear_err)    state <= ST_RUN;
               default:                    state <= ST_RUN;
            endcase
         end
      end
   end

   assign arb_state = state;

endmodule
